// File: rtl/main_memory_responder.sv
// Main-memory end of the cache line protocol: one fill/writeback at a time,
// fixed access latency, response returned under a valid/ready handshake.
module main_memory_responder #(
    parameter int unsigned LINE_BITS = 128,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [31:0]          req_addr,
    input  logic [LINE_BITS-1:0] req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [LINE_BITS-1:0] resp_rdata,
    output logic                 busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    logic [LINE_BITS-1:0] memArray [0:DEPTH-1];

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 write_q, write_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [LINE_BITS-1:0] wdata_q, wdata_d;
    logic [LINE_BITS-1:0] rdata_d;
    logic                 mem_we_c;

    // Offset and above-index address bits carry no meaning here; indexing wraps.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[3:0], req_addr[31:4+IDX_W]};

    // Next-state, capture and commit decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        write_d  = write_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        rdata_d  = resp_rdata;
        mem_we_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    idx_d   = req_addr[4+IDX_W-1:4];
                    wdata_d = req_wdata;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d  = RESP;
                    mem_we_c = write_q;
                    rdata_d  = write_q ? wdata_q : memArray[idx_q];
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and registered handshake outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            write_q    <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            resp_rdata <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            write_q    <= write_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            resp_rdata <= rdata_d;
            req_ready  <= (state_d == IDLE);
            resp_valid <= (state_d == RESP);
            busy       <= (state_d != IDLE);
        end
    end

    // Line storage has no reset; a write lands only on the BUSY->RESP edge.
    always_ff @(posedge clock) begin
        if (mem_we_c) begin
            memArray[idx_q] <= wdata_q;
        end
    end

endmodule

// File: doc/main_memory_responder.md
# main_memory_responder

Multi-cycle main-memory responder serving 128-bit cache-line fill and writeback requests from the data cache in the memory stage. It is the memory end of the cache-to-memory line protocol. It accepts one request at a time, waits a fixed latency, and then returns the line (read) or an acknowledge (write) under a valid/ready response handshake. Line storage is the array `memArray[0:DEPTH-1]`, which benches preload hierarchically; reset never clears it.

## Interface
Parameters:
- `LINE_BITS`, 128: line width; 4 × 32-bit words, word0 in bits [31:0].
- `DEPTH`, 1024: number of lines; power of two.
- `LATENCY`, 5: cycles from request acceptance to response valid; must be ≥ 1.

Ports:
- `clock` input, 1: single clock; all state updates on the rising edge.
- `reset` input, 1: asynchronous, active-high.
- `req_valid` input, 1: request present.
- `req_ready` output, 1: responder can accept a request.
- `req_write` input, 1: 1 = writeback, 0 = line fill.
- `req_addr` input, 32: byte address; line index = `req_addr[4+$clog2(DEPTH)-1:4]`.
- `req_wdata` input, LINE_BITS: writeback line.
- `resp_valid` output, 1: response present.
- `resp_ready` input, 1: cache accepts the response.
- `resp_rdata` output, LINE_BITS: line read, or the written line on a write acknowledge.
- `busy` output, 1: state ≠ IDLE.

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`: capture `req_write`, the line index and `req_wdata`; load counter = LATENCY-1; go to BUSY.
- **BUSY**
  - `req_ready`=0.
  - Counter decrements each cycle.
  - When counter==0 at an edge, go to RESP:
    - read: `resp_rdata` ← `memArray[idx]`;
    - write: `memArray[idx]` ← captured wdata, and `resp_rdata` ← captured wdata.
- **RESP**
  - `resp_valid`=1; `resp_rdata` is held stable.
  - On `resp_ready`, go to IDLE.
- Request side effects:
  - A write commits exactly once, at the BUSY→RESP edge.
  - Inputs are ignored outside the IDLE acceptance edge.
  - `req_addr[3:0]` and the upper address bits above the index are ignored, so indexing wraps modulo DEPTH.
- Counter width is `$clog2(LATENCY)`, minimum 1. With LATENCY=1, IDLE→BUSY→RESP takes one BUSY cycle.
- Reset (asynchronous, any state):
  - state = IDLE;
  - `req_ready`=1, `resp_valid`=0, `busy`=0, `resp_rdata`=0, counter=0;
  - any pending request is discarded, and an uncommitted write is never applied;
  - `memArray` keeps its contents.

## Timing
- Request accepted at edge T0 (`req_valid` && `req_ready`).
- `resp_valid` rises after edge T0+LATENCY.
- Response completes at the first edge with `resp_valid` && `resp_ready`.
- `req_ready` returns high in the following cycle; there is a mandatory one-cycle IDLE gap before a new request can be accepted.
- Minimum request-to-request spacing: LATENCY+2 cycles.
- Read data reflects every write committed before the BUSY→RESP edge.
- `resp_rdata` is undefined-free: it holds its last value when `resp_valid`=0.
- `resp_ready` stalled low in RESP: the block holds indefinitely with `resp_valid` and `resp_rdata` unchanged.
- `req_valid` low in IDLE: the block stays in IDLE.
- Reset asserted mid-RESP: `resp_valid` drops immediately (asynchronously).

## Test plan
- **Reset values:** assert `reset` for 2 cycles → `req_ready`=1, `resp_valid`=0, `busy`=0, `resp_rdata`=0; preloaded `memArray[3]` unchanged.
- **Read latency:** preload `memArray[0]` = {32'd3, 32'd2, 32'd1, 32'd0}; read `req_addr`=0x0, accepted at T0 → `resp_valid` first high after T0+5, `resp_rdata`=0x00000003_00000002_00000001_00000000; `req_ready` high again in the cycle after the handshake.
- **Write then read:** write `req_addr`=0x20 with 0xDEADBEEF_…_CAFEF00D → ack returns the same data; a subsequent read of 0x20 returns it; `memArray[2]` equals it.
- **Response stall:** hold `resp_ready`=0 for 10 cycles in RESP → `resp_valid` stays 1, `resp_rdata` is stable, and a `req_valid` presented meanwhile is not accepted (`req_ready`=0).
- **Reset mid-write:** write to 0x40 is accepted; assert `reset` 2 cycles later (in BUSY) → `memArray[4]` keeps its old value, state returns to IDLE, and no `resp_valid` appears.
- **Address wrap:** read `req_addr`=0x4010 with DEPTH=1024 → returns `memArray[1]`; offset bits 0x4 vs 0x0 give an identical response.
